kaly_subbytes_seq: RTL and testbench

Byte-serial SubBytes sequencer for the encryption datapath. Accepts a 128-bit state block over a valid/ready handshake and substitutes every byte through shared 8-bit S-box lookup instances, BYTES_PER_CYCLE bytes per clock. Returns the substituted block over a second valid/ready handshake. Sits between round-key mixing and the permutation/mixing stage, replacing sixteen parallel S-boxes with a small time-multiplexed set.

---
 rtl/kaly_pkg.sv | 23 ++
 rtl/kaly_sbox4.sv | 30 +++
 rtl/kaly_subbytes_seq.sv | 115 +++++++++++
 tb/tb_kaly_subbytes_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/kaly_pkg.sv
// Shared types and constants for the Kalyna-style SubBytes sequencer.
package kaly_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } kaly_state_e;

    localparam int BLOCK_W = 128;
    localparam int BYTE_W  = 8;
    localparam int NBYTES  = BLOCK_W / BYTE_W;

    // Bit n set means BYTES_PER_CYCLE == n is a legal configuration (1, 2, 4, 8, 16).
    localparam logic [16:0] BPC_LEGAL = 17'b1_0000_0001_0001_0110;

    function automatic bit bpc_is_legal(input int n);
        logic [4:0] idx;
        idx = n[4:0];
        return (n >= 1) && (n <= 16) && BPC_LEGAL[idx];
    endfunction

endpackage

// File: rtl/kaly_sbox4.sv
// 8-bit combinational S-box: row = x[7:4], column = x[3:0] into a fixed bijective table.
module kaly_sbox4
    import kaly_pkg::*;
(
    input  logic [BYTE_W-1:0] x,
    output logic [BYTE_W-1:0] y
);

    localparam logic [BYTE_W-1:0] SBOX [16][16] = '{
        '{8'h68, 8'h8d, 8'hca, 8'h4d, 8'h73, 8'h4b, 8'h4e, 8'h2a, 8'hd4, 8'h52, 8'h26, 8'hb3, 8'h54, 8'h1e, 8'h19, 8'h1f},
        '{8'h22, 8'h03, 8'h46, 8'h3d, 8'h2d, 8'h4a, 8'h53, 8'h83, 8'h13, 8'h8a, 8'hb7, 8'hd5, 8'h25, 8'h79, 8'hf5, 8'hbd},
        '{8'h58, 8'h2f, 8'h0d, 8'h02, 8'hed, 8'h51, 8'h9e, 8'h11, 8'hf2, 8'h3e, 8'h55, 8'h5e, 8'hd1, 8'h16, 8'h3c, 8'h66},
        '{8'h70, 8'h5d, 8'hf3, 8'h45, 8'h40, 8'hcc, 8'he8, 8'h94, 8'h56, 8'h08, 8'hce, 8'h1a, 8'h3a, 8'hd2, 8'he1, 8'hdf},
        '{8'hb5, 8'h38, 8'h6e, 8'h0e, 8'he5, 8'hf4, 8'hf9, 8'h86, 8'he9, 8'h4f, 8'hd6, 8'h85, 8'h23, 8'hcf, 8'h32, 8'h99},
        '{8'h31, 8'h14, 8'hae, 8'hee, 8'hc8, 8'h48, 8'hd3, 8'h30, 8'ha1, 8'h92, 8'h41, 8'hb1, 8'h18, 8'hc4, 8'h2c, 8'h71},
        '{8'h72, 8'h44, 8'h15, 8'hfd, 8'h37, 8'hbe, 8'h5f, 8'haa, 8'h9b, 8'h88, 8'hd8, 8'hab, 8'h89, 8'h9c, 8'hfa, 8'h60},
        '{8'hea, 8'hbc, 8'h62, 8'h0c, 8'h24, 8'ha6, 8'ha8, 8'hec, 8'h67, 8'h20, 8'hdb, 8'h7c, 8'h28, 8'hdd, 8'hac, 8'h5b},
        '{8'h34, 8'h7e, 8'h10, 8'hf1, 8'h7b, 8'h8f, 8'h63, 8'ha0, 8'h05, 8'h9a, 8'h43, 8'h77, 8'h21, 8'hbf, 8'h27, 8'h09},
        '{8'hc3, 8'h9f, 8'hb6, 8'hd7, 8'h29, 8'hc2, 8'heb, 8'hc0, 8'ha4, 8'h8b, 8'h8c, 8'h1d, 8'hfb, 8'hff, 8'hc1, 8'hb2},
        '{8'h97, 8'h2e, 8'hf8, 8'h65, 8'hf6, 8'h75, 8'h07, 8'h04, 8'h49, 8'h33, 8'he4, 8'hd9, 8'hb9, 8'hd0, 8'h42, 8'hc7},
        '{8'h6c, 8'h90, 8'h00, 8'h8e, 8'h6f, 8'h50, 8'h01, 8'hc5, 8'hda, 8'h47, 8'h3f, 8'hcd, 8'h69, 8'ha2, 8'he2, 8'h7a},
        '{8'ha7, 8'hc6, 8'h93, 8'h0f, 8'h0a, 8'h06, 8'he6, 8'h2b, 8'h96, 8'ha3, 8'h1c, 8'haf, 8'h6a, 8'h12, 8'h84, 8'h39},
        '{8'he7, 8'hb0, 8'h82, 8'hf7, 8'hfe, 8'h9d, 8'h87, 8'h5c, 8'h81, 8'h35, 8'hde, 8'hb4, 8'ha5, 8'hfc, 8'h80, 8'hef},
        '{8'hcb, 8'hbb, 8'h6b, 8'h76, 8'hba, 8'h5a, 8'h7d, 8'h78, 8'h0b, 8'h95, 8'he3, 8'had, 8'h74, 8'h98, 8'h3b, 8'h36},
        '{8'h64, 8'h6d, 8'hdc, 8'hf0, 8'h59, 8'ha9, 8'h4c, 8'h17, 8'h7f, 8'h91, 8'hb8, 8'hc9, 8'h57, 8'h1b, 8'he0, 8'h61}
    };

    assign y = SBOX[x[7:4]][x[3:0]];

endmodule

// File: rtl/kaly_subbytes_seq.sv
// Byte-serial SubBytes sequencer: BYTES_PER_CYCLE shared S-boxes sweep the 128-bit state in place.
// Optional completed-block counter port blk_count enabled by defining KALY_SUBBYTES_CNT_EN.
module kaly_subbytes_seq
    import kaly_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy
`ifdef KALY_SUBBYTES_CNT_EN
   ,output logic [15:0]        blk_count
`endif
);

    localparam int          NGRP      = NBYTES / BYTES_PER_CYCLE;
    localparam int          GRP_W     = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int unsigned BPC_U     = BYTES_PER_CYCLE;
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NGRP - 1);

    if (!bpc_is_legal(BYTES_PER_CYCLE)) begin : g_bpc_illegal
        $error("kaly_subbytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    kaly_state_e                      state;
    logic [NBYTES-1:0][BYTE_W-1:0]    st_q;
    logic [GRP_W-1:0]                 grp;
    logic [3:0]                       byte_idx [BYTES_PER_CYCLE];
    logic [BYTE_W-1:0]                sbox_in  [BYTES_PER_CYCLE];
    logic [BYTE_W-1:0]                sbox_out [BYTES_PER_CYCLE];

    // Group grp covers bytes grp*BPC .. grp*BPC+BPC-1, lowest byte on lookup lane 0.
    always_comb begin
        for (int unsigned i = 0; i < BPC_U; i++) begin
            byte_idx[i] = 4'(32'(grp) * BPC_U + i);
            sbox_in[i]  = st_q[byte_idx[i]];
        end
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
        kaly_sbox4 u_sbox (
            .x (sbox_in[g]),
            .y (sbox_out[g])
        );
    end

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_data = st_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            st_q      <= '0;
            grp       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st_q  <= in_data;
                        grp   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < BPC_U; i++) begin
                        st_q[byte_idx[i]] <= sbox_out[i];
                    end
                    if (grp == GRP_LAST) begin
                        grp       <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        grp <= grp + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // A new block may be captured on the same edge as the output handshake.
                        if (in_valid) begin
                            st_q  <= in_data;
                            grp   <= '0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KALY_SUBBYTES_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_count <= '0;
        end else if (out_valid && out_ready) begin
            blk_count <= blk_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_kaly_subbytes_seq.sv
// Directed self-checking bench for kaly_subbytes_seq (optionally with KALY_SUBBYTES_CNT_EN).
module tb_kaly_subbytes_seq;

    parameter int BPC = 1;
    localparam int NGRP = 16 / BPC;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef KALY_SUBBYTES_CNT_EN
    logic [15:0]  blk_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int hs_count = 0;

    localparam logic [127:0] ZERO_IN  = '0;
    localparam logic [127:0] ZERO_EXP = {16{8'h68}};
    localparam logic [127:0] RAMP_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] RAMP_EXP = 128'h1f191e54b32652d42a4e4b734dca8d68;
    localparam logic [127:0] FF_IN    = {16{8'hff}};
    localparam logic [127:0] FF_EXP   = {16{8'h61}};
    localparam logic [127:0] X10_IN   = {16{8'h10}};
    localparam logic [127:0] X10_EXP  = {16{8'h22}};
    localparam logic [127:0] MIX_IN   = {4{32'h00ff100f}};
    localparam logic [127:0] MIX_EXP  = {4{32'h6861221f}};

    kaly_subbytes_seq #(
        .BYTES_PER_CYCLE (BPC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef KALY_SUBBYTES_CNT_EN
       ,.blk_count (blk_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents din until accepted; returns one cycle after the accepting edge.
    task automatic accept(input string tag, input logic [127:0] din);
        int unsigned guard = 0;
        in_data  = din;
        in_valid = 1'b1;
        while (!in_ready && guard < 64) begin
            tick();
            guard++;
        end
        chk({tag, "_rdy"}, 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, 128'(busy), 128'(1));
    endtask

    task automatic wait_out(input string tag, input logic [127:0] exp);
        int unsigned lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 64);
        chk({tag, "_lat"}, 128'(lat), 128'(NGRP));
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_idle_busy"}, 128'(busy), 128'(0));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        hs_count++;
        chk({tag, "_ovld_low"}, 128'(out_valid), 128'(0));
    endtask

    task automatic run_block(input string tag, input logic [127:0] din, input logic [127:0] exp);
        accept(tag, din);
        wait_out(tag, exp);
        drain(tag);
    endtask

    initial begin
        logic [127:0] held;
        logic         seen_out;
        int unsigned  k;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) tick();

        chk("rst_ovld", 128'(out_valid), 128'(0));
        chk("rst_irdy", 128'(in_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_odata", out_data, 128'(0));
`ifdef KALY_SUBBYTES_CNT_EN
        chk("rst_cnt", 128'(blk_count), 128'(0));
`endif
        rst = 1'b0;
        tick();

        run_block("zero", ZERO_IN, ZERO_EXP);
        run_block("ramp", RAMP_IN, RAMP_EXP);
        run_block("allff", FF_IN, FF_EXP);
`ifdef KALY_SUBBYTES_CNT_EN
        chk("cnt3", 128'(blk_count), 128'(hs_count));
`endif
        run_block("all10", X10_IN, X10_EXP);

        // Back-pressure in DONE, then overlapped output handshake and new accept.
        accept("stall", MIX_IN);
        wait_out("stall", MIX_EXP);
        held = out_data;
        repeat (5) tick();
        chk("stall_data", out_data, held);
        chk("stall_irdy", 128'(in_ready), 128'(0));
        chk("stall_ovld", 128'(out_valid), 128'(1));
        in_data   = RAMP_IN;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("ovl_irdy", 128'(in_ready), 128'(1));
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        hs_count++;
        chk("ovl_ovld_low", 128'(out_valid), 128'(0));
        chk("ovl_busy", 128'(busy), 128'(1));
        wait_out("ovl", RAMP_EXP);
        drain("ovl");
`ifdef KALY_SUBBYTES_CNT_EN
        chk("cnt_ovl", 128'(blk_count), 128'(hs_count));
`endif

        // Asynchronous reset in the middle of RUN discards the block.
        accept("abort", FF_IN);
        k = (NGRP > 7) ? 7 : NGRP - 1;
        repeat (k) tick();
        rst = 1'b1;
        #1;
        chk("abort_ovld", 128'(out_valid), 128'(0));
        chk("abort_irdy", 128'(in_ready), 128'(1));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_odata", out_data, 128'(0));
        hs_count = 0;
`ifdef KALY_SUBBYTES_CNT_EN
        chk("abort_cnt", 128'(blk_count), 128'(0));
`endif
        tick();
        rst = 1'b0;
        seen_out = 1'b0;
        repeat (NGRP + 3) begin
            tick();
            if (out_valid) seen_out = 1'b1;
        end
        chk("abort_no_out", 128'(seen_out), 128'(0));
        run_block("post_rst", RAMP_IN, RAMP_EXP);
`ifdef KALY_SUBBYTES_CNT_EN
        chk("cnt_end", 128'(blk_count), 128'(hs_count));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
